bus_transaction_scheduler: RTL and testbench
============================================

# bus_transaction_scheduler

Target-side scheduler for the pipelined read/write bus. It accepts requests by driving `o_addressAck`, queues up to `MAX_PENDING` transactions in order and retires them in the same order with `o_readAck`/`o_writeAck` after a fixed minimum latency. A backend stall input can hold retirement. It is the response-generating counterpart that the bus protocol assertions check against.

## Interface
- `MAX_PENDING`, 4: maximum outstanding accepted-but-unacknowledged transactions; 2..8.
- `RESP_LATENCY`, 2: minimum number of cycles from `o_addressAck` to that transaction's response; 1..15.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_srst`  in  1  reset; synchronous, active-high.
- `i_req`  in  1  master requests a transaction this cycle.
- `i_readWrite_n`  in  1  transaction type, valid with `i_req`: 1 = read, 0 = write.
- `i_respStall`  in  1  backend not ready; blocks retirement this cycle.
- `o_addressAck`  out  1  request accepted this cycle; combinational from `i_req` and registered state.
- `o_readAck`  out  1  head read transaction retired this cycle.
- `o_writeAck`  out  1  head write transaction retired this cycle.
- `o_pending`  out  $clog2(MAX_PENDING+1)  registered count of queued transactions.

## Operation
- The queue is a circular buffer of `MAX_PENDING` entries. Each entry holds:
  - a type bit (1 = read);
  - an age countdown, $clog2(RESP_LATENCY+1) bits wide.
- The buffer uses wrapping read and write pointers plus a count register. Pointers wrap from `MAX_PENDING-1` to 0.
- **Accept:** `o_addressAck = i_req && !i_srst && (count < MAX_PENDING)`.
  - On accept, the entry at the write pointer is loaded with type = `i_readWrite_n` and age = `RESP_LATENCY-1`.
  - The write pointer then advances.
- **Aging:** every cycle, each valid entry with age > 0 decrements by 1. Age saturates at 0.
- **Retire:** `retire = (count != 0) && (head age == 0) && !i_respStall`.
  - `o_readAck = retire && head type`.
  - `o_writeAck = retire && !head type`.
  - The read pointer then advances.
- `o_readAck` and `o_writeAck` are never high in the same cycle. No response is ever issued with `count == 0`.
- **Count update:**
  - accept only: +1
  - retire only: −1
  - both in the same cycle: unchanged
  - neither: unchanged
- The count never exceeds `MAX_PENDING` and never underflows.
- Order is strict first-in first-out. Reads and writes share the one queue.
- A request that is not acknowledged is not recorded. The master re-presents it on a later cycle.

## Timing
- **Reset** (`i_srst` high at an edge):
  - count, both pointers and all ages clear to 0;
  - `o_pending` = 0;
  - all acknowledge outputs are forced to 0 while `i_srst` is high.
- **Reset mid-operation:** all queued entries are discarded. No acknowledge is issued for them after reset releases.
- **Latency:** if a transaction is accepted at cycle T and is at the head of an unstalled queue, it retires at T+`RESP_LATENCY`.
  - A non-head entry retires no earlier than one cycle after its predecessor.
  - Consecutive entries with expired age retire back-to-back, one per cycle.
- **Stall:** while `i_respStall` is high, the head holds with age 0. Younger entries keep aging. Acceptance continues while count < `MAX_PENDING`.
- **Full** (count == `MAX_PENDING`): `o_addressAck` stays 0 even if the head retires in that cycle, unless the macro below is defined.
- **Empty:** no acknowledges. An accept at T cannot retire before T+`RESP_LATENCY` (minimum 1), so the response never occurs in the same cycle as the request.

## Configuration
- Macro: `BUS_SCHED_FULL_BYPASS_EN`.
- **Defined:** when count == `MAX_PENDING` and `retire` is true in the same cycle, `o_addressAck = i_req`.
  - The new entry takes the freed slot and the count stays at `MAX_PENDING`.
  - `retire` does not depend on `i_req`, so there is no combinational loop.
- **Undefined:** acceptance requires count < `MAX_PENDING`, as described above. The count after any accept is at most `MAX_PENDING`.

## Test plan
- **Single read:** `RESP_LATENCY`=2. Read request at cycle 5 → `o_addressAck`=1 at 5, `o_readAck`=1 at 7 only; `o_pending` is 1 during cycle 6, 0 at 8.
- **Fill and block:** `MAX_PENDING`=4, `i_respStall`=1, `i_req`=1 for 6 cycles → exactly 4 acknowledges, then `o_addressAck`=0 and `o_pending`=4. With bypass defined: after stall drops, accept and retire occur in the same cycle and `o_pending` holds at 4.
- **Ordering:** W, R, W, R accepted back-to-back with no stall → responses on 4 consecutive cycles in the order writeAck, readAck, writeAck, readAck; acks are never simultaneous.
- **Simultaneous accept and retire:** `o_pending`=2, head expiring, new request → `o_pending` stays 2 and both acks occur in the same cycle.
- **Wrap-around:** 10 sequential transactions with `MAX_PENDING`=4 → all 10 responses are issued in order with correct types after the pointers wrap twice.
- **Mid-operation reset:** 3 pending, assert `i_srst` for 1 cycle → `o_pending`=0 the next cycle and no `o_readAck`/`o_writeAck` for 20 cycles without a new request.

Source files
------------

// File: rtl/bus_transaction_scheduler.sv
// In-order target-side scheduler: accepts requests, retires them FIFO after a minimum latency.
// Optional macro BUS_SCHED_FULL_BYPASS_EN lets a full queue accept into the slot freed by a retire.
module bus_transaction_scheduler #(
  parameter int MAX_PENDING  = 4,
  parameter int RESP_LATENCY = 2
) (
  input  logic                             i_clk,
  input  logic                             i_srst,
  input  logic                             i_req,
  input  logic                             i_readWrite_n,
  input  logic                             i_respStall,
  output logic                             o_addressAck,
  output logic                             o_readAck,
  output logic                             o_writeAck,
  output logic [$clog2(MAX_PENDING+1)-1:0] o_pending
);

  localparam int CW = $clog2(MAX_PENDING+1);
  localparam int PW = $clog2(MAX_PENDING);
  localparam int AW = $clog2(RESP_LATENCY+1);

  localparam logic [CW-1:0] FULL = CW'(MAX_PENDING);
  localparam logic [PW-1:0] LAST = PW'(MAX_PENDING-1);
  localparam logic [AW-1:0] AGE0 = AW'(RESP_LATENCY-1);

  logic [MAX_PENDING-1:0] kind;
  logic [AW-1:0]          age [MAX_PENDING];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   retire;
  logic                   accept;

  // Accept/retire decisions; retire never looks at i_req, so bypass has no loop.
  always_comb begin
    full   = (count == FULL);
    retire = !i_srst && (count != '0) &&
             (age[rd_ptr] == '0) && !i_respStall;
`ifdef BUS_SCHED_FULL_BYPASS_EN
    accept = i_req && !i_srst && (!full || retire);
`else
    accept = i_req && !i_srst && !full;
`endif
    o_addressAck = accept;
    o_readAck    = retire && kind[rd_ptr];
    o_writeAck   = retire && !kind[rd_ptr];
  end

  assign o_pending = count;

  // Queue storage, aging, pointers and occupancy count.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      kind   <= '0;
      for (int i = 0; i < MAX_PENDING; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_PENDING; i++) begin
        if (accept && wr_ptr == PW'(i)) begin
          kind[i] <= i_readWrite_n;
          age[i]  <= AGE0;
        end else if (age[i] != '0) begin
          age[i] <= age[i] - 1'b1;
        end
      end
      if (accept) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (retire) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_transaction_scheduler.sv
// Directed bench for bus_transaction_scheduler (MAX_PENDING=4, RESP_LATENCY=2).
// Vector table plus hand sequences for bypass, mid-operation reset and wrap-around.
module tb_bus_transaction_scheduler;

  logic       clk = 1'b0;
  logic       srst;
  logic       req;
  logic       rw;
  logic       stall;
  logic       aack;
  logic       rack;
  logic       wack;
  logic [2:0] pend;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_transaction_scheduler #(
    .MAX_PENDING (4),
    .RESP_LATENCY(2)
  ) dut (
    .i_clk        (clk),
    .i_srst       (srst),
    .i_req        (req),
    .i_readWrite_n(rw),
    .i_respStall  (stall),
    .o_addressAck (aack),
    .o_readAck    (rack),
    .o_writeAck   (wack),
    .o_pending    (pend)
  );

  typedef struct {
    logic srst;
    logic req;
    logic rw;
    logic stall;
    logic aack;
    logic rack;
    logic wack;
    int   pend;
  } vec_t;

  vec_t vecs[24];

`ifdef BUS_SCHED_FULL_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic q,
                       input logic t, input logic st);
    @(posedge clk);
    #1;
    srst  = s;
    req   = q;
    rw    = t;
    stall = st;
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic s, input logic q,
                              input logic t, input logic st,
                              input logic a, input logic r,
                              input logic w, input int p);
    vec_t v;
    v.srst  = s;
    v.req   = q;
    v.rw    = t;
    v.stall = st;
    v.aack  = a;
    v.rack  = r;
    v.wack  = w;
    v.pend  = p;
    return v;
  endfunction

  int          issued;
  int          resp;
  int          seen;
  logic        exp_t;
  logic        q_t[$];
  logic [9:0]  pattern;

  initial begin
    srst  = 1'b1;
    req   = 1'b0;
    rw    = 1'b0;
    stall = 1'b0;

    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 1, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(0, 1, 1, 0, 1, 0, 0, 1);
    vecs[8]  = mk(0, 1, 0, 0, 1, 0, 1, 2);
    vecs[9]  = mk(0, 1, 1, 0, 1, 1, 0, 2);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 2);
    vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 1, 1, 1, 0, 0, 0);
    vecs[14] = mk(0, 1, 0, 1, 1, 0, 0, 1);
    vecs[15] = mk(0, 1, 1, 1, 1, 0, 0, 2);
    vecs[16] = mk(0, 1, 0, 1, 1, 0, 0, 3);
    vecs[17] = mk(0, 1, 1, 1, 0, 0, 0, 4);
    vecs[18] = mk(0, 1, 0, 1, 0, 0, 0, 4);
    vecs[19] = mk(0, 0, 0, 0, 0, 1, 0, 4);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 3);
    vecs[21] = mk(0, 0, 0, 0, 0, 1, 0, 2);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 1, 1);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].srst, vecs[i].req, vecs[i].rw, vecs[i].stall);
      chk($sformatf("v%0d_aack", i), int'(aack), int'(vecs[i].aack));
      chk($sformatf("v%0d_rack", i), int'(rack), int'(vecs[i].rack));
      chk($sformatf("v%0d_wack", i), int'(wack), int'(vecs[i].wack));
      chk($sformatf("v%0d_pend", i), int'(pend), vecs[i].pend);
    end

    // Full queue with the head retiring while a new request is present.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 1);
      chk("fill_aack", int'(aack), 1);
    end
    drive(0, 1, 0, 0);
    chk("full_rt_aack", int'(aack), BYP);
    chk("full_rt_rack", int'(rack), 1);
    chk("full_rt_pend", int'(pend), 4);
    drive(0, 0, 0, 0);
    chk("full_rt_pend_next", int'(pend), BYP ? 4 : 3);
    seen = 0;
    for (int i = 0; i < 20 && pend != 0; i++) begin
      drive(0, 0, 0, 0);
      if (wack) seen++;
    end
    chk("full_rt_drained", int'(pend), 0);
    chk("full_rt_bypass_write", seen, BYP);

    // Reset with transactions still queued.
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 1);
    chk("rst_pre_pend", int'(pend), 2);
    drive(1, 0, 0, 0);
    chk("rst_cycle_acks", int'(rack | wack), 0);
    drive(0, 0, 0, 0);
    chk("rst_post_pend", int'(pend), 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0);
      if (rack || wack) seen++;
    end
    chk("rst_no_acks", seen, 0);

    // Ten transactions through the ring with occasional stalls.
    pattern = 10'b1011001110;
    issued  = 0;
    resp    = 0;
    for (int c = 0; c < 80 && resp < 10; c++) begin
      drive(0, issued < 10, pattern[issued % 10],
            $urandom_range(0, 3) == 0);
      if (rack && wack) chk("wrap_both_acks", 1, 0);
      if (rack || wack) begin
        if (q_t.size() == 0) begin
          chk("wrap_spurious_ack", 1, 0);
        end else begin
          exp_t = q_t.pop_front();
          chk($sformatf("wrap_type%0d", resp), int'(rack), int'(exp_t));
        end
        resp++;
      end
      if (aack) begin
        q_t.push_back(rw);
        issued++;
      end
    end
    chk("wrap_issued", issued, 10);
    chk("wrap_responses", resp, 10);
    drive(0, 0, 0, 0);
    chk("wrap_end_pend", int'(pend), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
